// File: rtl/dataflow_vector_sweeper_pkg.sv
// Shared types and helpers for the dataflow vector sweeper.
// Holds the state encoding, vector count and index-to-input mapping.
package dataflow_vector_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int unsigned NUM_VEC = 4;

    // idx[1] drives In1 and idx[0] drives In2, giving the order 00, 01, 10, 11.
    function automatic logic [1:0] vec_of(input logic [1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/dataflow_result_buf.sv
// Four-entry result register file.
// Has one write port, a combinational read port, async clear and per-entry valid bits.
module dataflow_result_buf
    import dataflow_vector_sweeper_pkg::*;
#(
    parameter int unsigned OUT_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_mask_i,
    input  logic               wr_en_i,
    input  logic [1:0]         wr_idx_i,
    input  logic [3*OUT_W-1:0] wr_data_i,
    input  logic [1:0]         rd_idx_i,
    output logic [3*OUT_W-1:0] rd_data_o,
    output logic [3:0]         valid_mask_o
);

    logic [3*OUT_W-1:0] mem_q [NUM_VEC];
    logic [3:0]         valid_mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_VEC; i++) begin
                mem_q[i] <= '0;
            end
            valid_mask_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_idx_i] <= wr_data_i;
            end
            // A new sweep only invalidates the mask; stale data stays readable.
            if (clr_mask_i) begin
                valid_mask_q <= '0;
            end else if (wr_en_i) begin
                valid_mask_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    assign rd_data_o    = mem_q[rd_idx_i];
    assign valid_mask_o = valid_mask_q;

endmodule

// File: rtl/dataflow_vector_sweeper.sv
// Sequences a 2-input/3-output datapath through its truth table.
// Each vector is settled, captured into the result buffer, then the next is driven.
module dataflow_vector_sweeper
    import dataflow_vector_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned OUT_W         = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               dut_in1,
    output logic               dut_in2,
    input  logic [OUT_W-1:0]   dut_o1,
    input  logic [OUT_W-1:0]   dut_o2,
    input  logic [OUT_W-1:0]   dut_o3,
    output logic               busy,
    output logic               done,
    output logic               sample_valid,
    output logic [1:0]         sample_idx,
    output logic [3:0]         valid_mask,
    input  logic [1:0]         rd_idx,
    output logic [3*OUT_W-1:0] rd_data
);

    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

    state_e     state_q;
    logic [1:0] idx_q;
    logic [7:0] cnt_q;
    logic       in1_q;
    logic       in2_q;
    logic       busy_q;
    logic       done_q;
    logic       sample_valid_q;
    logic [1:0] sample_idx_q;

    logic       start_sweep;
    logic       cap_en;

    assign start_sweep = (state_q == ST_IDLE) && start;
    // An abort landing on the capture edge suppresses the write.
    assign cap_en      = (state_q == ST_CAPTURE) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            in1_q          <= 1'b0;
            in2_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
        end else begin
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            if (state_q != ST_IDLE && abort) begin
                state_q         <= ST_IDLE;
                {in1_q, in2_q}  <= 2'b00;
                busy_q          <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            idx_q          <= '0;
                            {in1_q, in2_q} <= vec_of(2'd0);
                            cnt_q          <= CNT_RELOAD;
                            busy_q         <= 1'b1;
                            state_q        <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        sample_valid_q <= 1'b1;
                        sample_idx_q   <= idx_q;
                        if (idx_q == 2'd3) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q          <= idx_q + 2'd1;
                            {in1_q, in2_q} <= vec_of(idx_q + 2'd1);
                            cnt_q          <= CNT_RELOAD;
                            state_q        <= ST_SETTLE;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    dataflow_result_buf #(
        .OUT_W (OUT_W)
    ) u_buf (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_mask_i   (start_sweep),
        .wr_en_i      (cap_en),
        .wr_idx_i     (idx_q),
        .wr_data_i    ({dut_o1, dut_o2, dut_o3}),
        .rd_idx_i     (rd_idx),
        .rd_data_o    (rd_data),
        .valid_mask_o (valid_mask)
    );

    assign dut_in1      = in1_q;
    assign dut_in2      = in2_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;

endmodule

// File: tb/tb_dataflow_vector_sweeper.sv
// Directed bench for dataflow_vector_sweeper with a combinational datapath stub.
// A per-cycle expectation table covers the full sweep; short sequences cover abort/reset.
module tb_dataflow_vector_sweeper;

    localparam int unsigned OW = 2;

    typedef struct {
        logic [1:0] din;
        logic       busy;
        logic       done;
        logic       sv;
        logic [1:0] sidx;
        logic [3:0] vmask;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort;
    logic [1:0]    rd_idx;
    logic          in1, in2, busy, done, sv;
    logic [1:0]    sidx;
    logic [3:0]    vmask;
    logic [OW-1:0] o1, o2, o3;
    logic [3*OW-1:0] rd_data;

    logic          start_b, abort_b;
    logic [1:0]    rd_idx_b;
    logic          in1_b, in2_b, busy_b, done_b, sv_b;
    logic [1:0]    sidx_b;
    logic [3:0]    vmask_b;
    logic [OW-1:0] o1_b, o2_b, o3_b;
    logic [3*OW-1:0] rd_data_b;

    assign o1   = {in1, in2};
    assign o2   = {in2, in1};
    assign o3   = {in1 & in2, in1 | in2};
    assign o1_b = {in1_b, in2_b};
    assign o2_b = {in2_b, in1_b};
    assign o3_b = {in1_b & in2_b, in1_b | in2_b};

    dataflow_vector_sweeper #(.SETTLE_CYCLES(2), .OUT_W(OW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in1(in1), .dut_in2(in2), .dut_o1(o1), .dut_o2(o2), .dut_o3(o3),
        .busy(busy), .done(done), .sample_valid(sv), .sample_idx(sidx),
        .valid_mask(vmask), .rd_idx(rd_idx), .rd_data(rd_data)
    );

    dataflow_vector_sweeper #(.SETTLE_CYCLES(1), .OUT_W(OW)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .dut_in1(in1_b), .dut_in2(in2_b), .dut_o1(o1_b), .dut_o2(o2_b), .dut_o3(o3_b),
        .busy(busy_b), .done(done_b), .sample_valid(sv_b), .sample_idx(sidx_b),
        .valid_mask(vmask_b), .rd_idx(rd_idx_b), .rd_data(rd_data_b)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    row_t tbl [14];
    logic [5:0] exp_rd [4];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_row(input int k);
        chk($sformatf("din@%0d", k),   {6'd0, in1, in2}, {6'd0, tbl[k].din});
        chk($sformatf("busy@%0d", k),  {7'd0, busy},     {7'd0, tbl[k].busy});
        chk($sformatf("done@%0d", k),  {7'd0, done},     {7'd0, tbl[k].done});
        chk($sformatf("sv@%0d", k),    {7'd0, sv},       {7'd0, tbl[k].sv});
        chk($sformatf("vmask@%0d", k), {4'd0, vmask},    {4'd0, tbl[k].vmask});
        if (tbl[k].sv)
            chk($sformatf("sidx@%0d", k), {6'd0, sidx}, {6'd0, tbl[k].sidx});
    endtask

    // restart_cyc: edge at which start is re-asserted mid-sweep (-1 for none).
    task automatic run_sweep(input int restart_cyc);
        start = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            start = (k == restart_cyc - 1);
            check_row(k);
        end
        start = 1'b0;
    endtask

    task automatic check_rd(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            chk($sformatf("%s_rd%0d", tag, i), {2'd0, rd_data}, {2'd0, exp_rd[i]});
        end
    endtask

    initial begin
        tbl[0]  = '{2'b00, 1, 0, 0, 2'd0, 4'b0000};
        tbl[1]  = '{2'b00, 1, 0, 0, 2'd0, 4'b0000};
        tbl[2]  = '{2'b00, 1, 0, 0, 2'd0, 4'b0000};
        tbl[3]  = '{2'b01, 1, 0, 1, 2'd0, 4'b0001};
        tbl[4]  = '{2'b01, 1, 0, 0, 2'd0, 4'b0001};
        tbl[5]  = '{2'b01, 1, 0, 0, 2'd0, 4'b0001};
        tbl[6]  = '{2'b10, 1, 0, 1, 2'd1, 4'b0011};
        tbl[7]  = '{2'b10, 1, 0, 0, 2'd0, 4'b0011};
        tbl[8]  = '{2'b10, 1, 0, 0, 2'd0, 4'b0011};
        tbl[9]  = '{2'b11, 1, 0, 1, 2'd2, 4'b0111};
        tbl[10] = '{2'b11, 1, 0, 0, 2'd0, 4'b0111};
        tbl[11] = '{2'b11, 1, 0, 0, 2'd0, 4'b0111};
        tbl[12] = '{2'b11, 0, 1, 1, 2'd3, 4'b1111};
        tbl[13] = '{2'b11, 0, 0, 0, 2'd0, 4'b1111};
        exp_rd[0] = 6'b000000;
        exp_rd[1] = 6'b011001;
        exp_rd[2] = 6'b100101;
        exp_rd[3] = 6'b111111;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_idx = '0;
        start_b = 1'b0; abort_b = 1'b0; rd_idx_b = '0;
        #3;
        chk("rst_din",   {6'd0, in1, in2}, 8'd0);
        chk("rst_busy",  {7'd0, busy},     8'd0);
        chk("rst_done",  {7'd0, done},     8'd0);
        chk("rst_sv",    {7'd0, sv},       8'd0);
        chk("rst_sidx",  {6'd0, sidx},     8'd0);
        chk("rst_vmask", {4'd0, vmask},    8'd0);
        chk("rst_rd",    {2'd0, rd_data},  8'd0);
        #9 rst_n = 1'b1;

        // Full sweep, then mid-sweep restart attempt that must be ignored.
        run_sweep(-1);
        check_rd("s1");
        run_sweep(5);
        check_rd("s2");

        // Abort at edge 7: entries 0 and 1 stay valid, no done pulse.
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = (k == 6);
        end
        abort = 1'b0;
        chk("ab_din",   {6'd0, in1, in2}, 8'd0);
        chk("ab_busy",  {7'd0, busy},     8'd0);
        chk("ab_vmask", {4'd0, vmask},    8'b0000_0011);
        rd_idx = 2'd1; #1;
        chk("ab_rd1",   {2'd0, rd_data},  {2'd0, exp_rd[1]});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("ab_done%0d", k), {7'd0, done}, 8'd0);
            chk($sformatf("ab_idle%0d", k), {7'd0, busy}, 8'd0);
        end
        run_sweep(-1);
        check_rd("s3");

        // Async reset between edges 8 and 9.
        start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre_rst_vmask", {4'd0, vmask}, 8'b0000_0011);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_din",   {6'd0, in1, in2}, 8'd0);
        chk("ar_busy",  {7'd0, busy},     8'd0);
        chk("ar_sv",    {7'd0, sv},       8'd0);
        chk("ar_vmask", {4'd0, vmask},    8'd0);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            chk($sformatf("ar_rd%0d", i), {2'd0, rd_data}, 8'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post_busy%0d", k), {7'd0, busy}, 8'd0);
            chk($sformatf("post_din%0d", k),  {6'd0, in1, in2}, 8'd0);
            chk($sformatf("post_sv%0d", k),   {7'd0, sv}, 8'd0);
        end

        // SETTLE_CYCLES=1: captures at edges 2, 4, 6, 8; done in cycle 8.
        start_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            chk($sformatf("b_din@%0d", k),  {6'd0, in1_b, in2_b}, (k < 8) ? 8'(k / 2) : 8'd3);
            chk($sformatf("b_busy@%0d", k), {7'd0, busy_b}, (k < 8) ? 8'd1 : 8'd0);
            chk($sformatf("b_done@%0d", k), {7'd0, done_b}, (k == 8) ? 8'd1 : 8'd0);
            chk($sformatf("b_sv@%0d", k),   {7'd0, sv_b},
                (k >= 2 && k <= 8 && k % 2 == 0) ? 8'd1 : 8'd0);
            if (k >= 2 && k <= 8 && k % 2 == 0)
                chk($sformatf("b_sidx@%0d", k), {6'd0, sidx_b}, 8'(k / 2 - 1));
        end
        chk("b_vmask", {4'd0, vmask_b}, 8'b0000_1111);
        for (int i = 0; i < 4; i++) begin
            rd_idx_b = 2'(i); #1;
            chk($sformatf("b_rd%0d", i), {2'd0, rd_data_b}, {2'd0, exp_rd[i]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
